// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, ACK levels and filter default.
package i2c_pkg;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;
   localparam int   I2C_FILT_LEN = 3;
   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, PTR, ACK_W, WDATA, RD_LOAD, RDATA, MACK, IGNORE
   } i2c_state_e;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronises and deglitches SCL/SDA, then flags SCL edges and START/STOP.
module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int FILT_LEN = I2C_FILT_LEN
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);
   logic [1:0]          r_scl_sync, r_sda_sync;
   logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
   logic                r_scl, r_sda, r_scl_d, r_sda_d;
   // idle bus is high, so everything resets to 1 to avoid a phantom START/STOP
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= '1;
         r_sda_hist <= '1;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda};
         r_scl_hist <= FILT_LEN'({r_scl_hist, r_scl_sync[1]});
         r_sda_hist <= FILT_LEN'({r_sda_hist, r_sda_sync[1]});
         r_scl      <= &r_scl_hist ? 1'b1 : ~|r_scl_hist ? 1'b0 : r_scl;
         r_sda      <= &r_sda_hist ? 1'b1 : ~|r_sda_hist ? 1'b0 : r_sda;
         r_scl_d    <= r_scl;
         r_sda_d    <= r_sda;
      end
   assign o_sda      = r_sda;
   assign o_scl_rise = r_scl & ~r_scl_d;
   assign o_scl_fall = ~r_scl & r_scl_d;
   assign o_start    = r_scl & r_scl_d & r_sda_d & ~r_sda;
   assign o_stop     = r_scl & r_scl_d & ~r_sda_d & r_sda;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a pointer-addressed byte register port.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLV_ADDR = 7'h48,
   parameter int         PTR_W    = 8,
   parameter int         FILT_LEN = I2C_FILT_LEN
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oen_o,
   output logic [PTR_W-1:0] reg_addr_o,
   output logic [7:0]       reg_wdata_o,
   output logic             reg_we_o,
   output logic             reg_re_o,
   input  logic [7:0]       reg_rdata_i,
   output logic             busy_o
);
   logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
   logic [7:0] w_byte;
   i2c_state_e r_state;
   logic [7:0] r_sr;
   logic [3:0] r_cnt;
   logic       r_rw, r_ph, r_mack;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .i_clk      (clk_i),
      .i_rst_n    (rst_n_i),
      .i_scl      (scl_i),
      .i_sda      (sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_byte  = {r_sr[6:0], w_sda};
   assign w_match = r_sr[6:0] == SLV_ADDR;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         r_state     <= IDLE;
         sda_oen_o   <= 1'b1;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         reg_we_o    <= 1'b0;
         reg_re_o    <= 1'b0;
         busy_o      <= 1'b0;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_rw        <= 1'b0;
         r_ph        <= 1'b0;
         r_mack      <= I2C_NACK;
      end else begin
         reg_we_o <= 1'b0;
         reg_re_o <= 1'b0;
         if (w_stop) begin
            r_state   <= IDLE;
            sda_oen_o <= 1'b1;
            busy_o    <= 1'b0;
         end else if (w_start) begin
            r_state   <= ADDR;
            sda_oen_o <= 1'b1;
            r_cnt     <= '0;
         end else
            case (r_state)
               ADDR: if (w_scl_rise) begin
                  r_sr  <= w_byte;
                  r_cnt <= r_cnt + 4'd1;
                  r_rw  <= w_sda;
                  r_ph  <= 1'b0;
                  if (r_cnt == 4'd7) begin
                     r_state <= w_match ? ACK_A : IGNORE;
                     if (w_match) busy_o <= 1'b1;
                  end
               end
               // first scl_fall drives ACK, second releases it and moves on
               ACK_A, ACK_W: begin
                  if (r_state == ACK_W && reg_we_o) reg_addr_o <= reg_addr_o + PTR_W'(1);
                  if (w_scl_fall) begin
                     r_ph      <= 1'b1;
                     r_cnt     <= '0;
                     sda_oen_o <= r_ph ? 1'b1 : I2C_ACK;
                     if (r_ph) begin
                        r_state  <= r_state == ACK_W ? WDATA : r_rw ? RD_LOAD : PTR;
                        reg_re_o <= r_state == ACK_A && r_rw;
                     end
                  end
               end
               PTR, WDATA: if (w_scl_rise) begin
                  r_sr  <= w_byte;
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     r_state <= ACK_W;
                     r_ph    <= 1'b0;
                     if (r_state == PTR)
                        reg_addr_o <= PTR_W'(w_byte);
                     else begin
                        reg_wdata_o <= w_byte;
                        reg_we_o    <= 1'b1;
                     end
                  end
               end
               // reg_re_o was raised on entry, so reg_rdata_i is valid now
               RD_LOAD: begin
                  r_sr      <= {reg_rdata_i[6:0], 1'b0};
                  sda_oen_o <= reg_rdata_i[7];
                  r_cnt     <= 4'd1;
                  r_state   <= RDATA;
               end
               RDATA: if (w_scl_fall) begin
                  r_sr      <= {r_sr[6:0], 1'b0};
                  r_cnt     <= r_cnt + 4'd1;
                  sda_oen_o <= r_cnt == 4'd8 ? 1'b1 : r_sr[7];
                  if (r_cnt == 4'd8) r_state <= MACK;
               end
               MACK: begin
                  if (w_scl_rise) begin
                     r_mack     <= w_sda;
                     reg_addr_o <= reg_addr_o + PTR_W'(1);
                  end
                  if (w_scl_fall) begin
                     r_state  <= r_mack == I2C_ACK ? RD_LOAD : IGNORE;
                     reg_re_o <= r_mack == I2C_ACK;
                  end
               end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level master driving the target, checked against a pointer/data model.
module tb_i2c_target_regs;
   import i2c_pkg::*;
   localparam int Q = 10;

   logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1, glitch = 1'b0;
   logic       sda_oen, reg_we, reg_re, busy, sda_bus;
   logic [7:0] reg_addr, reg_wdata, reg_rdata, mdl_ptr;
   logic [7:0] wbuf[6], rbuf[6];
   logic [15:0] q_we[$];
   logic [7:0]  q_re[$];
   int n_cmp = 0, n_err = 0, n_low = 0, n_busy = 0;

   always #5 clk = ~clk;
   assign sda_bus   = sda_m & sda_oen;
   assign reg_rdata = reg_addr ^ 8'hFF;

   i2c_target_regs dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .scl_i       (scl),
      .sda_i       (sda_bus),
      .sda_oen_o   (sda_oen),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_we_o    (reg_we),
      .reg_re_o    (reg_re),
      .reg_rdata_i (reg_rdata),
      .busy_o      (busy)
   );

   always @(posedge clk) begin
      if (reg_we) q_we.push_back({reg_addr, reg_wdata});
      if (reg_re) q_re.push_back(reg_addr);
      if (!sda_oen) n_low++;
      if (busy) n_busy++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_clk(Q);
      scl = 1'b1;   wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b0;   wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl = 1'b1;   wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      sda_m = b;
      wait_clk(Q / 2);
      if (glitch) begin scl = 1'b1; wait_clk(1); scl = 1'b0; end
      wait_clk(Q / 2);
      scl = 1'b1;
      wait_clk(Q / 2);
      if (glitch) begin scl = 1'b0; wait_clk(1); scl = 1'b1; end
      wait_clk(Q / 2);
      r = sda_bus;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
      bus_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, r); d[i] = r; end
      bus_bit(nack, r);
   endtask

   task automatic master_write(input logic [7:0] ptr, input int n, input logic stop, output logic [7:0] acks);
      logic a;
      acks = '0;
      bus_start();
      wr_byte(8'h90, a); acks[0] = a;
      wr_byte(ptr, a);   acks[1] = a;
      for (int i = 0; i < n; i++) begin wr_byte(wbuf[i], a); acks[i+2] = a; end
      if (stop) bus_stop();
   endtask

   task automatic master_read(input int n, output logic ack);
      bus_start();
      wr_byte(8'h91, ack);
      for (int i = 0; i < n; i++) rd_byte(i == n - 1, rbuf[i]);
      bus_stop();
   endtask

   task automatic test_reset();
      wait_clk(3);
      n_cmp++;
      if ({sda_oen, reg_we, reg_re, busy, reg_addr, reg_wdata} !== {4'b1000, 16'h0}) begin
         n_err++; $display("FAIL reset_in: got %b want %b", {sda_oen, reg_we, reg_re, busy, reg_addr, reg_wdata}, {4'b1000, 16'h0});
      end
      rst_n = 1'b1;
      wait_clk(Q);
      n_cmp++;
      if ({sda_oen, reg_we, reg_re, busy, reg_addr, reg_wdata} !== {4'b1000, 16'h0}) begin
         n_err++; $display("FAIL reset_out: got %b want %b", {sda_oen, reg_we, reg_re, busy, reg_addr, reg_wdata}, {4'b1000, 16'h0});
      end
      mdl_ptr = 8'h00;
   endtask

   task automatic test_write();
      logic [7:0] acks;
      int base;
      base = q_we.size();
      wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
      master_write(8'h10, 2, 1'b0, acks);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
      bus_stop();
      mdl_ptr = 8'h12;
      n_cmp++;
      if (acks !== 8'h00) begin n_err++; $display("FAIL wr_acks: got %b want %b", acks, 8'h00); end
      n_cmp++;
      if (q_we.size() - base != 2) begin n_err++; $display("FAIL wr_count: got %0d want 2", q_we.size() - base); end
      else begin
         n_cmp++;
         if (q_we[base] !== 16'h10AA) begin n_err++; $display("FAIL wr_first: got %h want 10aa", q_we[base]); end
         n_cmp++;
         if (q_we[base+1] !== 16'h1155) begin n_err++; $display("FAIL wr_second: got %h want 1155", q_we[base+1]); end
      end
      n_cmp++;
      if ({busy, reg_addr} !== {1'b0, mdl_ptr}) begin n_err++; $display("FAIL wr_end: got %b/%h want 0/%h", busy, reg_addr, mdl_ptr); end
   endtask

   task automatic test_read_rs();
      logic [7:0] acks, e;
      logic a;
      int base;
      base = q_re.size();
      master_write(8'h20, 0, 1'b0, acks);
      master_read(3, a);
      n_cmp++;
      if ({acks, a} !== 9'h0) begin n_err++; $display("FAIL rd_acks: got %b want 0", {acks, a}); end
      for (int i = 0; i < 3; i++) begin
         e = 8'(8'h20 + i) ^ 8'hFF;
         n_cmp++;
         if (rbuf[i] !== e) begin n_err++; $display("FAIL rd_byte%0d: got %h want %h", i, rbuf[i], e); end
      end
      n_cmp++;
      if (q_re.size() - base != 3) begin n_err++; $display("FAIL rd_re_count: got %0d want 3", q_re.size() - base); end
      else for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (q_re[base+i] !== 8'(8'h20 + i)) begin n_err++; $display("FAIL rd_re%0d: got %h want %h", i, q_re[base+i], 8'(8'h20 + i)); end
      end
      mdl_ptr = 8'h23;
      n_cmp++;
      if (reg_addr !== mdl_ptr) begin n_err++; $display("FAIL rd_ptr: got %h want %h", reg_addr, mdl_ptr); end
   endtask

   task automatic test_mismatch();
      logic a, b, g;
      int low0, busy0, we0, re0;
      low0 = n_low; busy0 = n_busy; we0 = q_we.size(); re0 = q_re.size();
      bus_start();
      wr_byte(8'h92, a);
      wr_byte(8'h10, b);
      wr_byte(8'h33, b);
      bus_stop();
      bus_start();
      wr_byte(8'h00, g);
      bus_stop();
      n_cmp++;
      if ({a, g} !== 2'b11) begin n_err++; $display("FAIL mm_nack: got %b want 11", {a, g}); end
      n_cmp++;
      if (n_low != low0) begin n_err++; $display("FAIL mm_sda: got %0d low cycles want 0", n_low - low0); end
      n_cmp++;
      if (n_busy != busy0) begin n_err++; $display("FAIL mm_busy: got %0d busy cycles want 0", n_busy - busy0); end
      n_cmp++;
      if (q_we.size() != we0 || q_re.size() != re0) begin
         n_err++; $display("FAIL mm_strobes: got %0d/%0d want 0/0", q_we.size() - we0, q_re.size() - re0);
      end
      bus_start();
      wr_byte(8'h90, a);
      bus_stop();
      n_cmp++;
      if (a !== I2C_ACK) begin n_err++; $display("FAIL mm_recover: got %b want 0", a); end
      n_cmp++;
      if (reg_addr !== mdl_ptr) begin n_err++; $display("FAIL addr_only_ptr: got %h want %h", reg_addr, mdl_ptr); end
   endtask

   task automatic test_wrap();
      logic [7:0] acks;
      int base;
      base = q_we.size();
      wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
      master_write(8'hFF, 2, 1'b1, acks);
      mdl_ptr = 8'h01;
      n_cmp++;
      if (acks !== 8'h00) begin n_err++; $display("FAIL wrap_acks: got %b want 0", acks); end
      n_cmp++;
      if (q_we.size() - base != 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", q_we.size() - base); end
      else begin
         n_cmp++;
         if ({q_we[base], q_we[base+1]} !== 32'hFF3C_00C3) begin
            n_err++; $display("FAIL wrap_writes: got %h %h want ff3c 00c3", q_we[base], q_we[base+1]);
         end
      end
      n_cmp++;
      if (reg_addr !== mdl_ptr) begin n_err++; $display("FAIL wrap_ptr: got %h want %h", reg_addr, mdl_ptr); end
   endtask

   task automatic test_glitch();
      logic [7:0] acks;
      int base;
      base = q_we.size();
      wbuf[0] = 8'($urandom);
      glitch = 1'b1;
      master_write(8'h5A, 1, 1'b1, acks);
      glitch = 1'b0;
      mdl_ptr = 8'h5B;
      n_cmp++;
      if (acks !== 8'h00) begin n_err++; $display("FAIL gl_acks: got %b want 0", acks); end
      n_cmp++;
      if (q_we.size() - base != 1) begin n_err++; $display("FAIL gl_count: got %0d want 1", q_we.size() - base); end
      else begin
         n_cmp++;
         if (q_we[base] !== {8'h5A, wbuf[0]}) begin n_err++; $display("FAIL gl_write: got %h want %h", q_we[base], {8'h5A, wbuf[0]}); end
      end
      n_cmp++;
      if (reg_addr !== mdl_ptr) begin n_err++; $display("FAIL gl_ptr: got %h want %h", reg_addr, mdl_ptr); end
   endtask

   task automatic test_random();
      logic [7:0] acks, p, e;
      logic a;
      int nw, nr, base;
      for (int it = 0; it < 8; it++) begin
         p  = 8'($urandom);
         nw = $urandom_range(0, 3);
         for (int i = 0; i < nw; i++) wbuf[i] = 8'($urandom);
         base = q_we.size();
         master_write(p, nw, 1'b1, acks);
         n_cmp++;
         if (acks !== 8'h00) begin n_err++; $display("FAIL rnd%0d_acks: got %b want 0", it, acks); end
         n_cmp++;
         if (q_we.size() - base != nw) begin n_err++; $display("FAIL rnd%0d_wcount: got %0d want %0d", it, q_we.size() - base, nw); end
         else for (int i = 0; i < nw; i++) begin
            n_cmp++;
            if (q_we[base+i] !== {8'(p + i), wbuf[i]}) begin
               n_err++; $display("FAIL rnd%0d_w%0d: got %h want %h", it, i, q_we[base+i], {8'(p + i), wbuf[i]});
            end
         end
         mdl_ptr = 8'(p + nw);
         if ($urandom_range(0, 1) == 1) begin
            bus_start();
            wr_byte(8'h90, a);
            bus_stop();
            n_cmp++;
            if ({a, reg_addr} !== {I2C_ACK, mdl_ptr}) begin n_err++; $display("FAIL rnd%0d_addr_only: got %b/%h want 0/%h", it, a, reg_addr, mdl_ptr); end
         end
         nr = $urandom_range(1, 4);
         base = q_re.size();
         master_read(nr, a);
         n_cmp++;
         if (a !== I2C_ACK) begin n_err++; $display("FAIL rnd%0d_rack: got %b want 0", it, a); end
         for (int i = 0; i < nr; i++) begin
            e = 8'(mdl_ptr + i) ^ 8'hFF;
            n_cmp++;
            if (rbuf[i] !== e) begin n_err++; $display("FAIL rnd%0d_r%0d: got %h want %h", it, i, rbuf[i], e); end
         end
         n_cmp++;
         if (q_re.size() - base != nr) begin n_err++; $display("FAIL rnd%0d_rcount: got %0d want %0d", it, q_re.size() - base, nr); end
         else if (q_re[base] !== mdl_ptr) begin
            n_err++; $display("FAIL rnd%0d_rfirst: got %h want %h", it, q_re[base], mdl_ptr);
         end
         mdl_ptr = 8'(mdl_ptr + nr);
         n_cmp++;
         if (reg_addr !== mdl_ptr) begin n_err++; $display("FAIL rnd%0d_ptr: got %h want %h", it, reg_addr, mdl_ptr); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] acks, ad;
      logic r;
      int t;
      master_write(8'h33, 0, 1'b1, acks);
      n_cmp++;
      if ({acks, reg_addr} !== {8'h00, 8'h33}) begin n_err++; $display("FAIL rm_pre: got %b/%h want 0/33", acks, reg_addr); end
      ad = 8'h90;
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(ad[i], r);
      t = 0;
      while (sda_oen !== 1'b0 && t < 4 * Q) begin wait_clk(1); t++; end
      n_cmp++;
      if (sda_oen !== 1'b0) begin n_err++; $display("FAIL rm_ack_drive: got %b want 0", sda_oen); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sda_oen !== 1'b1) begin n_err++; $display("FAIL rm_release: got %b want 1", sda_oen); end
      n_cmp++;
      if (dut.r_state !== IDLE || reg_addr !== 8'h00 || busy !== 1'b0) begin
         n_err++; $display("FAIL rm_state: got %0d/%h/%b want %0d/00/0", dut.r_state, reg_addr, busy, IDLE);
      end
      scl = 1'b1; sda_m = 1'b1;
      wait_clk(2 * Q);
      rst_n = 1'b1;
      wait_clk(Q);
      master_write(8'h07, 0, 1'b1, acks);
      n_cmp++;
      if ({acks, reg_addr} !== {8'h00, 8'h07}) begin n_err++; $display("FAIL rm_after: got %b/%h want 0/07", acks, reg_addr); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_rs();
      test_mismatch();
      test_wrap();
      test_glitch();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
